// File: rtl/read_stream_stage.sv
// Read-side output stage of an async FIFO: 2-entry skid buffer toward a
// valid/ready stream, plus registered occupancy, pointer-sanity flag and beat count.
module read_stream_stage #(
    parameter int DW = 32
) (
    input  logic          rclk,
    input  logic          rrst,
    input  logic          rempty,
    input  logic [DW-1:0] rdata,
    input  logic [4:0]    wptr_rclk,
    input  logic [4:0]    rptr,
    output logic          rpop,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready,
    output logic [4:0]    rlevel,
    output logic          rerr,
    output logic [15:0]   beat_cnt
);

    // Handshake: a beat transfers on a rising edge where m_valid=1 and m_ready=1;
    // m_valid never drops and m_data never changes while m_ready=0.

    logic [1:0]    cnt;
    logic [1:0]    cnt_next;
    logic [DW-1:0] e0;
    logic [DW-1:0] e1;
    logic          push;
    logic          deq;
    logic [4:0]    wbin;
    logic [4:0]    rbin;
    logic [4:0]    diff;

    function automatic logic [4:0] gray2bin(input logic [4:0] g);
        logic [4:0] b;
        b[4] = g[4];
        for (int i = 3; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // Pop decision looks only at local fill, so m_ready never reaches rpop combinationally.
    assign rpop = ~rempty & ~cnt[1] & ~rrst;
    assign push = rpop;
    assign deq  = m_valid & m_ready;

    always_comb begin
        cnt_next = cnt + {1'b0, push} - {1'b0, deq};
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            cnt     <= 2'd0;
            m_valid <= 1'b0;
            e0      <= '0;
            e1      <= '0;
        end else begin
            cnt     <= cnt_next;
            m_valid <= (cnt_next != 2'd0);
            case (cnt)
                2'd0: begin
                    if (push) e0 <= rdata;
                end
                2'd1: begin
                    if (push && deq) e0 <= rdata;
                    else if (push)   e1 <= rdata;
                end
                2'd2: begin
                    if (deq) e0 <= e1;
                end
                default: ;
            endcase
        end
    end

    assign m_data = e0;

    assign wbin = gray2bin(wptr_rclk);
    assign rbin = gray2bin(rptr);
    assign diff = wbin - rbin;

    // A difference beyond the FIFO depth means the pointers are inconsistent.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rlevel <= 5'd0;
            rerr   <= 1'b0;
        end else begin
            rlevel <= diff;
            if (diff > 5'd16) rerr <= 1'b1;
        end
    end

    always_ff @(posedge rclk) begin
        if (rrst) begin
            beat_cnt <= 16'd0;
        end else if (deq && (beat_cnt != 16'hFFFF)) begin
            beat_cnt <= beat_cnt + 16'd1;
        end
    end

endmodule
